// File: rtl/stochastic_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : stochastic_add_sequencer (plus leaf stochastic_adder)
//  Purpose  : Runs one stochastic scaled addition end to end. Two unsigned
//             operands are turned into bitstreams by LFSR-driven comparators.
//             A third LFSR supplies the select stream for a combinational
//             stochastic adder. The adder's ones are counted over BIT_LENGTH
//             cycles, and the count is returned through a valid/ready
//             handshake.
//  Ports    : clk, rst_n (sync, active low)
//             start, a_val[8:0], b_val[8:0]    - request and operands
//             busy, bit_valid                  - run status
//             res_valid, res_ready, result[7:0] - result handshake
//             a_bit, b_bit, sel_bit, y_bit     - per-bit trace (0 outside RUN)
//  Revision : 1.0  initial release
// ============================================================================

// Scaled adder: the select bit picks a or b, so P(y) = (P(a)+P(b))/2.
module stochastic_adder (
  input  logic a,
  input  logic b,
  input  logic rand_bit,
  output logic y
);
  assign y = rand_bit ? a : b;
endmodule

module stochastic_add_sequencer #(
  parameter int unsigned BIT_LENGTH = 128,
  parameter logic [7:0]  SEED_A     = 8'hA5,
  parameter logic [7:0]  SEED_B     = 8'h3C,
  parameter logic [7:0]  SEED_S     = 8'h5E
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] a_val,
  input  logic [8:0] b_val,
  output logic       busy,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] result,
  output logic       bit_valid,
  output logic       a_bit,
  output logic       b_bit,
  output logic       sel_bit,
  output logic       y_bit
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] C_SEED_A   = (SEED_A == 8'h00) ? 8'h01 : SEED_A;
  localparam logic [7:0] C_SEED_B   = (SEED_B == 8'h00) ? 8'h01 : SEED_B;
  localparam logic [7:0] C_SEED_S   = (SEED_S == 8'h00) ? 8'h01 : SEED_S;
  localparam logic [7:0] C_LAST_IDX = 8'(BIT_LENGTH - 1);

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1 (maximal length, period 255).
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [1:0] state_q, state_d;
  logic [7:0] lfsr_a_q, lfsr_b_q, lfsr_s_q;
  logic [8:0] a_op_q, b_op_q;
  logic [7:0] bit_cnt_q;
  logic [7:0] ones_q;
  logic [7:0] result_q;
  logic       in_run;
  logic       last_bit;
  logic       adder_y;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  assign last_bit = (bit_cnt_q == C_LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_RUN;
      S_RUN:   if (last_bit)  state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    in_run    = (state_q == S_RUN);
    busy      = in_run;
    bit_valid = in_run;
    res_valid = (state_q == S_DONE);
  end

  // Stream bits are forced low outside RUN so the traces read as idle.
  assign a_bit   = in_run & ({1'b0, lfsr_a_q} < a_op_q);
  assign b_bit   = in_run & ({1'b0, lfsr_b_q} < b_op_q);
  assign sel_bit = in_run & lfsr_s_q[0];

  stochastic_adder u_adder (
    .a        (a_bit),
    .b        (b_bit),
    .rand_bit (sel_bit),
    .y        (adder_y)
  );

  assign y_bit  = adder_y;
  assign result = result_q;

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_a_q  <= C_SEED_A;
      lfsr_b_q  <= C_SEED_B;
      lfsr_s_q  <= C_SEED_S;
      a_op_q    <= 9'd0;
      b_op_q    <= 9'd0;
      bit_cnt_q <= 8'd0;
      ones_q    <= 8'd0;
      result_q  <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_op_q    <= a_val;
            b_op_q    <= b_val;
            lfsr_a_q  <= C_SEED_A;
            lfsr_b_q  <= C_SEED_B;
            lfsr_s_q  <= C_SEED_S;
            bit_cnt_q <= 8'd0;
            ones_q    <= 8'd0;
          end
        end
        S_RUN: begin
          lfsr_a_q <= lfsr_step(lfsr_a_q);
          lfsr_b_q <= lfsr_step(lfsr_b_q);
          lfsr_s_q <= lfsr_step(lfsr_s_q);
          ones_q   <= ones_q + {7'd0, adder_y};
          if (last_bit) begin
            // Include the final bit, which is not yet in ones_q.
            result_q <= ones_q + {7'd0, adder_y};
          end else begin
            bit_cnt_q <= bit_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stochastic_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stochastic_add_sequencer
//  Purpose  : Self-checking bench. A reference model derives each run's
//             expected bit streams and count directly from the LFSR/SNG/adder
//             rules. A negedge compare process checks every output on every
//             cycle against the expectations that the driver publishes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stochastic_add_sequencer;

  localparam int BL = 128;

  logic       clk = 1'b0;
  logic       rst_n, start, res_ready;
  logic [8:0] a_val, b_val;
  logic       busy, res_valid, bit_valid, a_bit, b_bit, sel_bit, y_bit;
  logic [7:0] result;

  always #5 clk = ~clk;

  stochastic_add_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_val     (a_val),
    .b_val     (b_val),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .sel_bit   (sel_bit),
    .y_bit     (y_bit)
  );

  int errors = 0;
  int checks = 0;
  int bv_count = 0;

  // Expected outputs for the current cycle, set by the driver after each edge.
  logic       chk_en = 1'b0;
  logic       e_busy, e_valid, e_a, e_b, e_s, e_y;
  logic [7:0] e_result;

  // Reference model of one run.
  logic ma [BL];
  logic mb [BL];
  logic ms [BL];
  logic my [BL];
  int   msum, msel;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic model_run(input logic [8:0] a, input logic [8:0] b);
    logic [7:0] ra, rb, rs;
    ra = 8'hA5; rb = 8'h3C; rs = 8'h5E;
    msum = 0; msel = 0;
    for (int i = 0; i < BL; i++) begin
      ma[i] = ({1'b0, ra} < a);
      mb[i] = ({1'b0, rb} < b);
      ms[i] = rs[0];
      my[i] = ms[i] ? ma[i] : mb[i];
      msum += int'(my[i]);
      msel += int'(ms[i]);
      ra = lfsr_next(ra); rb = lfsr_next(rb); rs = lfsr_next(rs);
    end
  endtask

  // Per-cycle compare process.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({busy, bit_valid, res_valid, a_bit, b_bit, sel_bit, y_bit} !==
          {e_busy, e_busy, e_valid, e_a, e_b, e_s, e_y} || result !== e_result) begin
        errors++;
        $display("FAIL outputs t=%0t got busy/bv/valid/a/b/s/y=%b res=%0d want %b res=%0d",
                 $time, {busy, bit_valid, res_valid, a_bit, b_bit, sel_bit, y_bit}, result,
                 {e_busy, e_busy, e_valid, e_a, e_b, e_s, e_y}, e_result);
      end
      if (bit_valid === 1'b1) bv_count++;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle(input logic [7:0] r);
    e_busy = 0; e_valid = 0; e_a = 0; e_b = 0; e_s = 0; e_y = 0; e_result = r;
  endtask

  // Full transaction. stop_at >= 0 pulses reset while bit stop_at is shown.
  task automatic run_flow(input logic [8:0] a, input logic [8:0] b, input int ready_delay,
                          input logic start_on_release, input int stop_at,
                          output int res, output logic [BL-1:0] ytr);
    model_run(a, b);
    ytr = '0;
    res = -1;
    a_val = a; b_val = b; start = 1'b1;
    tick;
    start = 1'b0;
    // Operand changes after acceptance must not matter.
    a_val = 9'($urandom_range(256)); b_val = 9'($urandom_range(256));
    for (int i = 0; i < BL; i++) begin
      e_busy = 1; e_valid = 0;
      e_a = ma[i]; e_b = mb[i]; e_s = ms[i]; e_y = my[i];
      ytr[i] = y_bit;
      if (i == stop_at) begin
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        set_idle(8'd0);
        tick;
        return;
      end
      tick;
    end
    set_idle(8'(msum));
    e_valid = 1;
    res_ready = 1'b0;
    for (int d = 0; d < ready_delay; d++) begin
      start = 1'($urandom_range(1));
      tick;
    end
    start = start_on_release;
    res_ready = 1'b1;
    tick;
    res = int'(result);
    set_idle(8'(msum));
    res_ready = 1'b0;
    start = 1'b0;
    tick;
    tick;
  endtask

  int              r1, r2, r3, r4, r5, b0;
  logic [BL-1:0]   t1, t2, t3, t4, t5;
  logic [8:0]      ra_, rb_;

  initial begin
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0; a_val = '0; b_val = '0;
    set_idle(8'd0);

    // Pin the model itself with hand-derived values.
    chk("lfsr_pin_A5", int'(lfsr_next(8'hA5)), 32'h4A);
    model_run(9'd0, 9'd0);     chk("model_zero", msum, 0);
    model_run(9'd256, 9'd256); chk("model_full", msum, 128);

    tick; tick;
    chk_en = 1'b1;
    rst_n = 1'b1;
    tick;

    // 0 + 0
    b0 = bv_count;
    run_flow(9'd0, 9'd0, 2, 1'b0, -1, r1, t1);
    chk("zero_result", r1, 0);
    chk("zero_bit_valid_cnt", bv_count - b0, BL);

    // 256 + 256
    run_flow(9'd256, 9'd256, 0, 1'b0, -1, r1, t1);
    chk("full_result", r1, 128);
    chk("full_y_all_ones", int'(t1 == {BL{1'b1}}), 1);

    // Complementary runs pick out sel=1 and sel=0 counts.
    run_flow(9'd256, 9'd0, 1, 1'b0, -1, r1, t1);
    chk("a_only_eq_sel1", r1, msel);
    run_flow(9'd0, 9'd256, 1, 1'b0, -1, r2, t2);
    chk("b_only_eq_sel0", r2, BL - msel);
    chk("complement_sum", r1 + r2, 128);

    // Half + half, repeatability; DONE held 10 cycles, start on release.
    run_flow(9'd128, 9'd128, 10, 1'b1, -1, r3, t3);
    chk("half_in_range", int'(r3 >= 48 && r3 <= 80), 1);
    run_flow(9'd128, 9'd128, 3, 1'b1, -1, r4, t4);
    chk("half_repeat_result", r4, r3);
    chk("half_repeat_trace", int'(t4 == t3), 1);

    // Reset in the middle of a run, then a clean rerun.
    run_flow(9'd128, 9'd128, 0, 1'b0, 40, r5, t5);
    chk("mid_reset_result", int'(result), 0);
    run_flow(9'd128, 9'd128, 0, 1'b0, -1, r5, t5);
    chk("post_reset_result", r5, r3);
    chk("post_reset_trace", int'(t5 == t3), 1);

    // Randomized operands.
    for (int k = 0; k < 8; k++) begin
      ra_ = 9'($urandom_range(256));
      rb_ = 9'($urandom_range(256));
      run_flow(ra_, rb_, int'($urandom_range(4)), 1'($urandom_range(1)), -1, r1, t1);
      chk("rand_result", r1, msum);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
